mac_result_collector: RTL and testbench

MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_col_fifo.sv | 78 +++++++
 rtl/mac_result_collector.sv | 132 +++++++++++++
 tb/tb_mac_result_collector.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared defaults, state encoding and index-width helper for the MAC result collector.
package mac_pkg;

  localparam int MAC_COLS = 4;
  localparam int MAC_ROWS = 4;
  localparam int MAC_DW   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } mac_state_e;

  // Index width that stays legal (>=1 bit) for a single-entry dimension.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_col_fifo.sv
// Per-column first-word-fall-through FIFO; head is valid whenever empty=0.
module mac_col_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = MAC_ROWS,
  parameter int DW    = MAC_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mac_result_collector.sv
// Collects per-column systolic results and emits them row-major with valid/ready.
// Optional ReLU on the output word: define MAC_COLLECT_RELU_EN.
//   state | meaning
//   IDLE  | waiting for start, column strobes ignored
//   RUN   | storing column results and draining them row-major
//   FLUSH | one cycle after the last word, done=1
module mac_result_collector
  import mac_pkg::*;
#(
  parameter int COLS = MAC_COLS,
  parameter int ROWS = MAC_ROWS,
  parameter int DW   = MAC_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [COLS-1:0]          col_valid,
  input  logic [COLS*DW-1:0]       col_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [idx_w(ROWS)-1:0]   out_row,
  output logic [idx_w(COLS)-1:0]   out_col,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err_ovf
);

  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);

  mac_state_e    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          err_ovf_q, err_ovf_d;

  logic          run;
  logic          start_acc;
  logic          xfer;
  logic          at_last;
  logic [COLS-1:0] push, pop, full, empty, ovf;
  logic [DW-1:0]   head [COLS];
  logic [DW-1:0]   head_sel;

  assign run       = (state_q == RUN);
  assign start_acc = (state_q == IDLE) & start;
  assign at_last   = (row_q == RW'(ROWS - 1)) & (col_q == CW'(COLS - 1));
  assign head_sel  = head[col_q];
  assign out_valid = run & ~empty[col_q];
  assign xfer      = out_valid & out_ready;
  assign out_last  = out_valid & at_last;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign busy      = run;
  assign done      = (state_q == FLUSH);
  assign err_ovf   = err_ovf_q;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign push[c] = run & col_valid[c];
    assign pop[c]  = xfer & (col_q == CW'(c));
    assign ovf[c]  = push[c] & full[c] & ~pop[c];

    mac_col_fifo #(
      .DEPTH (ROWS),
      .DW    (DW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start_acc),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   (col_data[c*DW +: DW]),
      .full  (full[c]),
      .empty (empty[c]),
      .head  (head[c])
    );
  end

  always_comb begin
    out_data = head_sel;
`ifdef MAC_COLLECT_RELU_EN
    if (head_sel[DW-1]) out_data = '0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    err_ovf_d = err_ovf_q | (|ovf);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          row_d     = '0;
          col_d     = '0;
          err_ovf_d = 1'b0;
        end
      end
      RUN: begin
        if (xfer) begin
          if (at_last) state_d = FLUSH;
          // Pointer wraps back to (0,0) after the final word.
          if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      err_ovf_q <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed self-checking bench for mac_result_collector (4x4, 32-bit).
`timescale 1ns/1ps
module tb_mac_result_collector;

  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [COLS-1:0]    col_valid = '0;
  logic [COLS*DW-1:0] col_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [DW-1:0]      out_data;
  logic [1:0]         out_row;
  logic [1:0]         out_col;
  logic               out_last;
  logic               busy;
  logic               done;
  logic               err_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_result_collector #(.COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .col_valid (col_valid),
    .col_data  (col_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err_ovf   (err_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer recorder and stall-hold checker, sampled mid-cycle.
  logic [DW-1:0] q_data[$];
  int            q_row[$], q_col[$], q_last[$], q_cyc[$];
  int            cyc = 0, done_cnt = 0, done_cyc = -1, last_cyc = -1;
  int            hold_cnt = 0, c3_cyc = -1;
  logic          stall_p = 1'b0;
  logic [DW-1:0] p_data;
  logic [1:0]    p_row, p_col;
  logic          p_last;

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && col_valid[3] && c3_cyc < 0) c3_cyc = cyc;
    if (stall_p && out_valid) begin
      hold_cnt++;
      chk("hold_data", out_data, p_data);
      chk("hold_row", out_row, p_row);
      chk("hold_col", out_col, p_col);
      chk("hold_last", out_last, p_last);
    end
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_row.push_back(int'(out_row));
      q_col.push_back(int'(out_col));
      q_last.push_back(int'(out_last));
      q_cyc.push_back(cyc);
      if (out_last) last_cyc = cyc;
    end
    stall_p = out_valid && !out_ready;
    p_data  = out_data;
    p_row   = out_row;
    p_col   = out_col;
    p_last  = out_last;
  end

  task automatic clear_rec();
    q_data.delete(); q_row.delete(); q_col.delete(); q_last.delete(); q_cyc.delete();
    c3_cyc   = -1;
    last_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_inorder();
    for (int r = 0; r < ROWS; r++) begin
      col_valid = '1;
      for (int c = 0; c < COLS; c++) col_data[c*DW +: DW] = 32'(10*r + c);
      @(posedge clk); #1;
    end
    col_valid = '0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  task automatic chk_tile(input string tag);
    logic [DW-1:0] e;
    chk({tag, "_words"}, q_data.size(), 16);
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      e = 32'(10*(i/4) + (i%4));
      chk($sformatf("%s_data%0d", tag, i), q_data[i], e);
      chk($sformatf("%s_row%0d", tag, i), q_row[i], i/4);
      chk($sformatf("%s_col%0d", tag, i), q_col[i], i%4);
      chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == 15) ? 1 : 0);
    end
  endtask

  initial begin
    int d0, h0, n, lag, r;
    logic [DW-1:0] e_neg;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    chk("rst_last", out_last, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Strobes in IDLE are discarded, then an in-order tile
    col_valid = '1;
    for (int c = 0; c < COLS; c++) col_data[c*DW +: DW] = 32'd555;
    @(posedge clk); #1;
    col_valid = '0;
    chk("idle_ignore_busy", busy, 0);
    clear_rec();
    out_ready = 1'b1;
    d0 = done_cnt;
    do_start();
    chk("ino_busy", busy, 1);
    drive_inorder();
    wait_done("ino", d0);
    chk_tile("ino");
    chk("ino_done_lat", done_cyc - last_cyc, 1);
    chk("ino_busy_after", busy, 0);

    // Column 3 lags by 3 cycles; a start while busy is ignored
    clear_rec();
    d0 = done_cnt;
    do_start();
    for (int k = 0; k < 7; k++) begin
      col_valid = '0;
      start = (k == 2);
      for (int c = 0; c < COLS; c++) begin
        lag = (c == 3) ? 3 : 0;
        r = k - lag;
        if (r >= 0 && r < ROWS) begin
          col_valid[c] = 1'b1;
          col_data[c*DW +: DW] = 32'(10*r + c);
        end
      end
      @(posedge clk); #1;
    end
    col_valid = '0;
    start = 1'b0;
    wait_done("skw", d0);
    chk_tile("skw");
    if (q_cyc.size() > 3) chk("skw_c3_wait", q_cyc[3] - c3_cyc, 1);

    // Backpressure: out_ready 1,0,0,1 repeating
    clear_rec();
    d0 = done_cnt;
    h0 = hold_cnt;
    do_start();
    fork
      drive_inorder();
      begin
        int i = 0;
        while (done_cnt == d0 && i < 200) begin
          out_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk); #1;
          i++;
        end
        out_ready = 1'b1;
      end
    join
    chk("bp_done_pulses", done_cnt - d0, 1);
    chk_tile("bp");
    chk("bp_holds_seen", hold_cnt > h0, 1);

    // Overflow: fifth push on column 1 must be dropped
    clear_rec();
    out_ready = 1'b0;
    d0 = done_cnt;
    do_start();
    for (int k = 0; k < 5; k++) begin
      col_valid = (k < 4) ? 4'b1111 : 4'b0010;
      for (int c = 0; c < COLS; c++) col_data[c*DW +: DW] = 32'(10*k + c);
      if (k == 4) col_data[1*DW +: DW] = 32'd99;
      @(posedge clk); #1;
    end
    col_valid = '0;
    @(posedge clk); #1;
    chk("ovf_flag", err_ovf, 1);
    chk("ovf_busy", busy, 1);
    chk("ovf_no_xfer", q_data.size(), 0);
    out_ready = 1'b1;
    wait_done("ovf", d0);
    chk_tile("ovf");
    chk("ovf_sticky", err_ovf, 1);

    // Reset mid-tile after 6 transfers
    clear_rec();
    do_start();
    chk("ovf_cleared", err_ovf, 0);
    drive_inorder();
    n = 0;
    while (q_data.size() < 6 && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    rst_n = 1'b0;
    d0 = done_cnt;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_row", out_row, 0);
    chk("mrst_col", out_col, 0);
    chk("mrst_last", out_last, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_xfers", q_data.size(), 6);
    chk("mrst_no_done", done_cnt - d0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_no_done_after", done_cnt - d0, 0);
    clear_rec();
    d0 = done_cnt;
    do_start();
    drive_inorder();
    wait_done("post", d0);
    chk_tile("post");

    // Negative and positive values through the output stage
    clear_rec();
    do_start();
    col_valid = 4'b0011;
    col_data[0 +: DW]  = 32'hFFFF_FFFB;
    col_data[DW +: DW] = 32'd7;
    @(posedge clk); #1;
    col_valid = '0;
    repeat (4) @(posedge clk);
    #1;
`ifdef MAC_COLLECT_RELU_EN
    e_neg = 32'd0;
`else
    e_neg = 32'hFFFF_FFFB;
`endif
    chk("relu_words", q_data.size(), 2);
    if (q_data.size() >= 2) begin
      chk("relu_neg", q_data[0], e_neg);
      chk("relu_pos", q_data[1], 32'd7);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
